// File: rtl/lenet_layer_seq.sv
// LeNet layer sequencer: paces c1..c5 settle/latch strobes,
// then scans the ten class scores for the signed argmax.
module lenet_layer_seq #(
  parameter int SETTLE_CYCLES = 2,
  parameter int OUTLEN        = 10,
  parameter int RES_W         = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [4:0]       ld_o,
  output logic [2:0]       layer_o,
  output logic [3:0]       res_sel_o,
  input  logic [RES_W-1:0] res_data_i,
  output logic [3:0]       class_o,
  output logic             class_valid_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_LATCH,
    S_SCAN,
    S_DONE
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
  localparam logic [3:0] LAST_IDX = 4'(OUTLEN - 1);

  state_t           state_q, state_d;
  logic [2:0]       layer_q, layer_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [RES_W-1:0] max_q, max_d;
  logic [3:0]       arg_q, arg_d;
  logic [3:0]       class_q, class_d;
  logic             cv_q, cv_d;
  logic             take;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      layer_q <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      max_q   <= '0;
      arg_q   <= '0;
      class_q <= '0;
      cv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      max_q   <= max_d;
      arg_q   <= arg_d;
      class_q <= class_d;
      cv_q    <= cv_d;
    end
  end

  // First score seeds the max; later ones replace it only if strictly greater.
  assign take = (idx_q == 4'd0) ||
                ($signed(res_data_i) > $signed(max_q));

  always_comb begin
    state_d = state_q;
    layer_d = layer_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    max_d   = max_q;
    arg_d   = arg_q;
    class_d = class_q;
    cv_d    = cv_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          state_d = S_SETTLE;
          layer_d = '0;
          cnt_d   = CNT_INIT;
          class_d = '0;
          cv_d    = 1'b0;
        end
      end
      S_SETTLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
          cv_d    = 1'b0;
        end else if (cnt_q == 4'd0) begin
          state_d = S_LATCH;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_LATCH: begin
        if (abort_i) begin
          state_d = S_IDLE;
          cv_d    = 1'b0;
        end else if (layer_q == 3'd4) begin
          state_d = S_SCAN;
          idx_d   = '0;
        end else begin
          state_d = S_SETTLE;
          layer_d = layer_q + 3'd1;
          cnt_d   = CNT_INIT;
        end
      end
      S_SCAN: begin
        if (abort_i) begin
          state_d = S_IDLE;
          cv_d    = 1'b0;
        end else begin
          if (take) begin
            max_d = res_data_i;
            arg_d = idx_q;
          end
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
            class_d = take ? idx_q : arg_q;
            cv_d    = 1'b1;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (abort_i) cv_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o        = (state_q != S_IDLE);
    done_o        = (state_q == S_DONE) && !abort_i;
    ld_o          = '0;
    layer_o       = '0;
    res_sel_o     = '0;
    class_o       = class_q;
    class_valid_o = cv_q && !((state_q == S_DONE) && abort_i);
    if (state_q == S_LATCH && !abort_i)
      ld_o = 5'b00001 << layer_q;
    if (state_q == S_SETTLE || state_q == S_LATCH)
      layer_o = layer_q;
    if (state_q == S_SCAN && !abort_i)
      res_sel_o = idx_q;
  end

endmodule

// File: tb/tb_lenet_layer_seq.sv
// Bench for lenet_layer_seq: cycle-accurate strobe checks plus
// an argmax scoreboard fed by a software model of the scores.
module tb_lenet_layer_seq;

  logic clk = 1'b0;
  logic rst;
  logic st0, ab0, st1, ab1;
  logic busy0, done0, cv0, busy1, done1, cv1;
  logic [4:0] ld0, ld1;
  logic [2:0] ly0, ly1;
  logic [3:0] rs0, rs1, cl0, cl1;
  logic [63:0] rd0, rd1;
  logic signed [63:0] sc [10];
  logic [3:0] exp_q [$];
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  lenet_layer_seq #(.SETTLE_CYCLES(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(st0), .abort_i(ab0),
    .busy_o(busy0), .done_o(done0), .ld_o(ld0), .layer_o(ly0),
    .res_sel_o(rs0), .res_data_i(rd0), .class_o(cl0),
    .class_valid_o(cv0));

  lenet_layer_seq #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(st1), .abort_i(ab1),
    .busy_o(busy1), .done_o(done1), .ld_o(ld1), .layer_o(ly1),
    .res_sel_o(rs1), .res_data_i(rd1), .class_o(cl1),
    .class_valid_o(cv1));

  function automatic logic [63:0] score(input logic [3:0] i);
    if (int'(i) < 10) return sc[int'(i)];
    return '0;
  endfunction

  assign rd0 = score(rs0);
  assign rd1 = score(rs1);

  function automatic logic [3:0] model_argmax();
    int b = 0;
    for (int i = 1; i < 10; i++)
      if (sc[i] > sc[b]) b = i;
    return 4'(b);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] obs(input bit sel);
    if (sel) return {busy1, done1, ld1, ly1, rs1, cv1};
    return {busy0, done0, ld0, ly0, rs0, cv0};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) st1 = v;
    else     st0 = v;
  endtask

  task automatic run(input bit sel, input bit busy_start);
    int s, lat, last;
    logic [3:0] expc;
    logic [4:0] eld;
    logic [2:0] ely;
    logic [3:0] ers;
    s    = sel ? 1 : 2;
    lat  = 5 * (s + 1);
    last = lat + 11;
    expc = '0;
    @(posedge clk); #1;
    set_start(sel, 1'b1);
    exp_q.push_back(model_argmax());
    @(posedge clk); #1;
    set_start(sel, 1'b0);
    for (int c = 1; c <= last + 2; c++) begin
      set_start(sel, busy_start && (c == lat + 3));
      @(negedge clk);
      eld = (c <= lat && c % (s + 1) == 0) ?
            5'(1 << (c / (s + 1) - 1)) : 5'd0;
      ely = (c <= lat) ? 3'((c - 1) / (s + 1)) : 3'd0;
      ers = (c > lat && c < last) ? 4'(c - lat - 1) : 4'd0;
      check($sformatf("s%0d_cyc%0d", s, c), obs(sel),
            {(c <= last), (c == last), eld, ely, ers, (c >= last)});
      if (c == last) begin
        if (exp_q.size() == 0) check("sb_empty", 1, 0);
        else expc = exp_q.pop_front();
      end
      if (c >= last)
        check($sformatf("s%0d_class%0d", s, c), sel ? cl1 : cl0, expc);
      @(posedge clk); #1;
    end
    set_start(sel, 1'b0);
  endtask

  task automatic abort_at(input int cyc);
    @(posedge clk); #1;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    repeat (cyc - 1) begin
      @(posedge clk); #1;
    end
    ab0 = 1'b1;
    @(negedge clk);
    check($sformatf("ab%0d_during", cyc),
          {busy0, done0, ld0, rs0, cv0}, {1'b1, 1'b0, 5'd0, 4'd0, 1'b0});
    if (cyc == 7) check("ab7_layer", ly0, 3'd2);
    @(posedge clk); #1;
    ab0 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check($sformatf("ab%0d_after", cyc), obs(1'b0), '0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst = 1'b1;
    st0 = 1'b0; ab0 = 1'b0; st1 = 1'b0; ab1 = 1'b0;
    for (int i = 0; i < 10; i++) sc[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst0", {obs(1'b0), cl0}, '0);
    check("rst1", {obs(1'b1), cl1}, '0);
    rst = 1'b0;

    sc = '{-5, 3, 7, 7, -1, 0, 2, 1, 6, -100};
    run(1'b0, 1'b0);

    for (int i = 0; i < 10; i++) sc[i] = 64'sh8000_0000_0000_0000;
    sc[7] = -2;
    run(1'b0, 1'b1);

    for (int i = 0; i < 10; i++) sc[i] = 64'sd42;
    run(1'b0, 1'b0);

    sc = '{1, -9, 4, 2, 11, 11, 3, -7, 0, 5};
    abort_at(7);
    abort_at(9);
    abort_at(18);
    abort_at(26);
    run(1'b0, 1'b0);

    @(posedge clk); #1;
    st0 = 1'b1; ab0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0; ab0 = 1'b0;
    @(negedge clk);
    check("start_abort_idle", busy0, 1'b0);

    @(posedge clk); #1;
    st0 = 1'b1;
    @(posedge clk); #1;
    st0 = 1'b0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("async_rst", {obs(1'b0), cl0}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_idle", obs(1'b0), '0);
    run(1'b0, 1'b0);

    sc = '{0, 0, 0, -3, 0, 8, 0, 8, 0, 0};
    run(1'b1, 1'b0);

    if (exp_q.size() != 0) check("sb_leftover", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
